// File: rtl/npu_mem_pkg.sv
// Shared definitions for the NPU SRAM bank family.
// Provides the read-during-write mode encoding, the clear sequencer state
// encoding, the byte width and a byte-enable merge helper used wherever a
// partially written word has to be reconstructed.
package npu_mem_pkg;

  localparam int BYTE_W     = 8;
  // Widest word the merge helper supports; callers cast in and out.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / BYTE_W;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } rdw_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clear_state_e;

  // Returns old_word with every byte whose enable is set replaced by the
  // corresponding byte of new_word.
  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) begin
        merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/npu_sram_clear_fsm.sv
// Zero-fill sequencer for the NPU SRAM bank.
// After reset it walks every word address once, writing all-zero data with
// all byte enables set, then hands the array write port to the user side.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   user_we       qualified user write request (ce & we & in range)
//   user_addr     user word address (also used as read address)
//   user_din      user write data
//   user_be       user byte enables
//   mem_we        array write enable after muxing
//   mem_addr      array address after muxing
//   mem_wdata     array write data after muxing
//   mem_be        array byte enables after muxing
//   run           high once the sequencer has finished (user accesses live)
//   init_busy     high while the zero-fill is in progress
module npu_sram_clear_fsm
  import npu_mem_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int BE_W         = DATA_W / 8,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              user_we,
  input  logic [ADDR_W-1:0] user_addr,
  input  logic [DATA_W-1:0] user_din,
  input  logic [BE_W-1:0]   user_be,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  output logic              run,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam clear_state_e RESET_STATE = (CLEAR_ON_RST != 0) ? CLEAR : RUN;

  clear_state_e      state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  // The last clear write and the switch to RUN share one edge, so init_busy
  // is high for exactly DEPTH cycles after reset release.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    mem_we    = user_we;
    mem_addr  = user_addr;
    mem_wdata = user_din;
    mem_be    = user_be;
    run       = 1'b1;
    init_busy = 1'b0;
    case (state)
      CLEAR: begin
        run       = 1'b0;
        init_busy = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ptr;
        mem_wdata = '0;
        mem_be    = '1;
        if (ptr == LAST_ADDR) begin
          state_n = RUN;
        end else begin
          ptr_n = ptr + ADDR_W'(1);
        end
      end
      RUN: begin
      end
      default: begin
        state_n = RESET_STATE;
      end
    endcase
  end

endmodule

// File: rtl/npu_sram_bank.sv
// Parametrised single-port synchronous SRAM bank for NPU operand/weight
// buffers, with per-byte write enables, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a post-reset zero-fill.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   ce         access enable
//   we         write enable (qualified by ce)
//   be         byte write enables, bit i covers din[8i+7:8i]
//   addr       word address
//   din        write data
//   dout       read data, held between valid reads
//   rvalid     one-cycle pulse aligned with new dout
//   init_busy  zero-fill in progress; accesses are ignored
module npu_sram_bank
  import npu_mem_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int BE_W         = DATA_W / 8,
  parameter int RD_LAT       = 1,
  parameter int RDW_MODE     = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic              init_busy
);

  localparam rdw_mode_e MODE = rdw_mode_e'(RDW_MODE[1:0]);

  logic              run;
  logic              in_range;
  logic              access;
  logic              produce;
  logic              rd_load;
  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] raw_q;

  logic              s1_valid;
  logic              s1_zero;
  logic              s1_wf;
  logic [DATA_W-1:0] s1_din;
  logic [BE_W-1:0]   s1_be;
  logic [DATA_W-1:0] s1_word;

  assign in_range = (32'(addr) < DEPTH);
  assign access   = run & ce;
  // A NO_CHANGE write is the only access that produces no read result.
  assign produce  = access & ~(we & (MODE == NO_CHANGE));
  assign rd_load  = produce & in_range;
  assign user_we  = ce & we & in_range;

  npu_sram_clear_fsm #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .BE_W         (BE_W),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clear (
    .clk       (clk),
    .rst       (rst),
    .user_we   (user_we),
    .user_addr (addr),
    .user_din  (din),
    .user_be   (be),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .run       (run),
    .init_busy (init_busy)
  );

  // Block RAM body: no reset, per-byte write loop, read-first synchronous
  // read. raw_q only loads on result-producing accesses so it also acts as
  // part of the dout hold state.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (mem_be[b]) begin
          mem[mem_addr][b*BYTE_W +: BYTE_W] <= mem_wdata[b*BYTE_W +: BYTE_W];
        end
      end
    end
    if (rd_load) begin
      raw_q <= mem[mem_addr];
    end
  end

  // Side information for the word read this cycle. WRITE_FIRST data is
  // rebuilt after the RAM register from the old word plus the registered
  // write data, keeping the RAM itself a plain read-first macro. s1_zero
  // resets high so dout reads 0 before any access, and also marks
  // out-of-range reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b1;
      s1_wf    <= 1'b0;
      s1_din   <= '0;
      s1_be    <= '0;
    end else begin
      s1_valid <= produce;
      if (produce) begin
        s1_zero <= ~in_range;
        s1_wf   <= we & (MODE == WRITE_FIRST);
        s1_din  <= din;
        s1_be   <= be;
      end
    end
  end

  always_comb begin
    s1_word = raw_q;
    if (s1_zero) begin
      s1_word = '0;
    end else if (s1_wf) begin
      s1_word = DATA_W'(be_merge(MAX_DATA_W'(raw_q), MAX_DATA_W'(s1_din),
                                 MAX_BE_W'(s1_be)));
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] dout_q;
      logic              rvalid_q;

      // Extra output register; only loads on a valid result so dout holds.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q   <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= s1_valid;
          if (s1_valid) begin
            dout_q <= s1_word;
          end
        end
      end

      assign dout   = dout_q;
      assign rvalid = rvalid_q;
    end else begin : g_lat1
      assign dout   = s1_word;
      assign rvalid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_npu_sram_bank.sv
// Self-checking bench for npu_sram_bank. Four banks share one stimulus
// stream: three 32-bit, 1000-word banks (READ_FIRST/lat 1, WRITE_FIRST/lat 2,
// NO_CHANGE/lat 1) and one 8-bit, 1024-word READ_FIRST bank. A reference
// model of memory contents, busy countdown and result delivery is compared
// with every bank after each clock edge.
module tb_npu_sram_bank;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  be  = '0;
  logic [9:0]  addr = '0;
  logic [31:0] din = '0;

  logic [31:0] dout0, dout1, dout2;
  logic [7:0]  dout3;
  logic        rvalid_a [NB];
  logic        busy_a   [NB];
  logic [31:0] dout_a   [NB];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          depth_k [NB] = '{1000, 1000, 1000, 1024};
  int          lat_k   [NB] = '{1, 2, 1, 1};
  int          mode_k  [NB] = '{0, 1, 2, 0};
  logic [31:0] wmask_k [NB] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] mdl_mem [NB][1024];
  logic        exp_valid [NB];
  logic [31:0] exp_dout  [NB];
  int          busy_cnt  [NB];
  logic        pend_v    [NB];
  logic [31:0] pend_d    [NB];

  always #5 clk = ~clk;

  npu_sram_bank #(.DATA_W(32), .DEPTH(1000), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RST(1)) u_b0 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout0), .rvalid(rvalid_a[0]), .init_busy(busy_a[0]));
  npu_sram_bank #(.DATA_W(32), .DEPTH(1000), .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RST(1)) u_b1 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout1), .rvalid(rvalid_a[1]), .init_busy(busy_a[1]));
  npu_sram_bank #(.DATA_W(32), .DEPTH(1000), .RD_LAT(1), .RDW_MODE(2), .CLEAR_ON_RST(1)) u_b2 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout2), .rvalid(rvalid_a[2]), .init_busy(busy_a[2]));
  npu_sram_bank #(.DATA_W(8), .DEPTH(1024), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RST(1)) u_b3 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be[0:0]), .addr(addr), .din(din[7:0]),
    .dout(dout3), .rvalid(rvalid_a[3]), .init_busy(busy_a[3]));

  assign dout_a[0] = dout0;
  assign dout_a[1] = dout1;
  assign dout_a[2] = dout2;
  assign dout_a[3] = {24'h0, dout3};

  // Reset wipes pending results and outputs; the zero-fill that follows
  // always completes before any access is honoured, so memory is modelled
  // as all-zero straight away.
  task automatic modelReset();
    for (int k = 0; k < NB; k++) begin
      exp_valid[k] = 1'b0;
      exp_dout[k]  = '0;
      pend_v[k]    = 1'b0;
      pend_d[k]    = '0;
      busy_cnt[k]  = depth_k[k];
      for (int a = 0; a < 1024; a++) mdl_mem[k][a] = '0;
    end
  endtask

  // One clock edge of the reference behaviour for the current inputs.
  task automatic modelEdge();
    logic        new_v;
    logic [31:0] new_d, old_w, bmask, merged;
    logic        inr;
    for (int k = 0; k < NB; k++) begin
      new_v = 1'b0;
      new_d = '0;
      if (busy_cnt[k] > 0) begin
        busy_cnt[k]--;
      end else if (ce) begin
        inr   = (int'(addr) < depth_k[k]);
        old_w = inr ? mdl_mem[k][addr] : 32'h0;
        bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        merged = ((old_w & ~bmask) | (din & bmask)) & wmask_k[k];
        if (we) begin
          if (inr) mdl_mem[k][addr] = merged;
          if (mode_k[k] == 0) begin
            new_v = 1'b1; new_d = old_w;
          end else if (mode_k[k] == 1) begin
            new_v = 1'b1; new_d = inr ? merged : 32'h0;
          end
        end else begin
          new_v = 1'b1; new_d = old_w;
        end
      end
      if (lat_k[k] == 1) begin
        exp_valid[k] = new_v;
        if (new_v) exp_dout[k] = new_d;
      end else begin
        exp_valid[k] = pend_v[k];
        if (pend_v[k]) exp_dout[k] = pend_d[k];
        pend_v[k] = new_v;
        pend_d[k] = new_d;
      end
    end
  endtask

  task automatic checkOne(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s bank%0d t=%0t observed=%h expected=%h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < NB; k++) begin
      checkOne("rvalid", k, {31'h0, rvalid_a[k]}, {31'h0, exp_valid[k]});
      checkOne("dout", k, dout_a[k], exp_dout[k]);
      checkOne("init_busy", k, {31'h0, busy_a[k]}, {31'h0, (busy_cnt[k] > 0)});
    end
  endtask

  // Drive one access, advance one edge, then compare away from the edge.
  task automatic applyStimulus(input logic c, input logic w, input logic [3:0] b,
                               input logic [9:0] a, input logic [31:0] d);
    ce = c; we = w; be = b; addr = a; din = d;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
  endtask

  task automatic randomAccess(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'($urandom), 1'($urandom), 4'($urandom), 10'($urandom), $urandom);
  endtask

  // Asserts reset asynchronously, checks the outputs clear immediately,
  // holds it for a few edges and releases it just after an edge.
  task automatic doReset(input int hold);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkOutput();
    end
    rst = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    doReset(3);

    // Clear phase: a write to address 5 right away must be dropped, then
    // random traffic until every bank has finished its zero-fill.
    applyStimulus(1'b1, 1'b1, 4'hF, 10'd5, 32'hDEAD_BEEF);
    randomAccess(1023);
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd5, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd511, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd1023, 32'h0);
    idle(2);

    // Latency and back-to-back reads
    applyStimulus(1'b1, 1'b1, 4'hF, 10'd10, 32'h0000_00A5);
    applyStimulus(1'b1, 1'b1, 4'hF, 10'd11, 32'h0000_003C);
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd10, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd11, 32'h0);
    idle(3);

    // Byte enables
    applyStimulus(1'b1, 1'b1, 4'hF, 10'd20, 32'h1122_3344);
    applyStimulus(1'b1, 1'b1, 4'b0101, 10'd20, 32'hAABB_CCDD);
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd20, 32'h0);
    idle(2);

    // Read-during-write modes, plus a be=0 write and read-after-write
    applyStimulus(1'b1, 1'b1, 4'hF, 10'd7, 32'h0000_0055);
    idle(1);
    applyStimulus(1'b1, 1'b1, 4'hF, 10'd7, 32'h0000_0099);
    idle(2);
    applyStimulus(1'b1, 1'b1, 4'h0, 10'd7, 32'h0000_0011);
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd7, 32'h0);
    idle(2);

    // Out-of-range on the 1000-word banks
    applyStimulus(1'b1, 1'b1, 4'hF, 10'd1010, 32'h1234_5678);
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd1010, 32'h0);
    idle(2);

    // Reset with non-zero dout, then again partway through the clear
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd20, 32'h0);
    doReset(2);
    idle(300);
    doReset(2);
    randomAccess(1024);

    // Reset with a latency-2 read in flight
    applyStimulus(1'b1, 1'b1, 4'hF, 10'd10, 32'h1234_5678);
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd10, 32'h0);
    doReset(1);
    idle(1024);

    // Random write-then-read pairs
    for (int i = 0; i < 1000; i++) begin
      logic [9:0] ra;
      ra = 10'($urandom_range(0, 1023));
      applyStimulus(1'b1, 1'b1, 4'($urandom), ra, $urandom);
      applyStimulus(1'b1, 1'b0, 4'h0, ra, 32'h0);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
